// File: rtl/dcache_pkg.sv
// dcache_pkg: op/flush/writeback codes, FSM states and per-line control record shared by the LRU data cache
package dcache_pkg;
    typedef enum logic {OP_WRITE = 1'b0, OP_READ = 1'b1} op_t;
    localparam logic [7:0] FLUSH_CODE = 8'd7;
    localparam logic [7:0] MEMWR_TAG = 8'hFF;
    localparam int ADDR_W = 64;
    typedef enum logic [2:0] {IDLE, LOOKUP, RDWAIT, EVRD, WB, FILL} state_t;
    typedef struct packed {
        logic valid;
        logic dirty;
        logic [ADDR_W-1:0] tag;
    } line_t;
endpackage

// File: rtl/mod_dcache_lru_set.sv
// dcache_lru_set: one set's LRU ages -> victim (lowest invalid, else oldest) and post-access ages for way
module dcache_lru_set #(
    parameter int WAYS = 4,
    parameter int AW = 2
) (
    input  logic [WAYS-1:0][AW-1:0] age,
    input  logic [WAYS-1:0]         valid,
    input  logic [AW-1:0]           way,
    output logic [AW-1:0]           victim,
    output logic [WAYS-1:0][AW-1:0] age_next
);
    always_comb begin
        victim = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (age[w] == AW'(WAYS - 1)) victim = AW'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[w]) victim = AW'(w);
        for (int w = 0; w < WAYS; w++)
            age_next[w] = AW'(w) == way ? '0 : age[w] < age[way] ? age[w] + 1'b1 : age[w];
    end
endmodule

// File: rtl/mod_dcache_lru.sv
// mod_dcache_lru: write-back/write-allocate N-way L1 dcache with true LRU; core_* request/response port, arb_* block port to memory
module mod_dcache_lru
    import dcache_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int LOGWIDTH = 6,
    parameter int LOGDEPTH = 9,
    parameter int LOGWAYS = 2,
    parameter int TAGWIDTH = 13,
    parameter int RDLAT = 1,
    localparam int BLKBITS = 8 << LOGWIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_reqcyc,
    output logic                core_reqack,
    input  logic [63:0]         core_req,
    input  logic [TAGWIDTH-1:0] core_reqtag,
    input  logic [WORDSIZE-1:0] core_reqdata,
    output logic                core_respcyc,
    output logic [BLKBITS-1:0]  core_resp,
    output logic [TAGWIDTH-1:0] core_resptag,
    output logic                arb_reqcyc,
    input  logic                arb_reqack,
    output logic [63:0]         arb_req,
    output logic [TAGWIDTH-1:0] arb_reqtag,
    output logic [BLKBITS-1:0]  arb_reqdata,
    input  logic                arb_respcyc,
    output logic                arb_respack,
    input  logic [BLKBITS-1:0]  arb_resp
);
    localparam int WAYS = 1 << LOGWAYS;
    localparam int AW = LOGWAYS > 0 ? LOGWAYS : 1;
    localparam int SETBITS = LOGDEPTH - LOGWAYS;
    localparam int SETS = 1 << SETBITS;
    localparam int TSH = LOGWIDTH + SETBITS;
    localparam int CW = $clog2(RDLAT + 1);
    localparam int WSW = LOGWIDTH - 3;
    state_t state, state_n;
    logic [63:0] req_q, req_tag, wb_addr;
    logic [TAGWIDTH-1:0] tag_q;
    logic [WORDSIZE-1:0] wd_q;
    logic [AW-1:0] way_q, hit_way, victim, acc_way, rd_way;
    logic [CW-1:0] cnt;
    logic sent_q, is_flush, is_write, any_hit, hit_dirty, vic_dirty, write_hit, respond, lru_upd;
    logic [BLKBITS-1:0] rd_q, fill_blk;
    logic [WAYS-1:0] hit, valid_v;
    logic [WAYS-1:0][AW-1:0] age_next;
    logic [SETBITS-1:0] idx;
    logic [WSW-1:0] wsel;
    line_t ctl [WAYS][SETS];
    logic [WAYS-1:0][AW-1:0] lru [SETS];
    logic [BLKBITS-1:0] data [WAYS][SETS];
    assign idx = req_q[LOGWIDTH +: SETBITS];
    assign req_tag = req_q >> TSH;
    assign wsel = req_q[3 +: WSW];
    assign is_flush = tag_q[7:0] == FLUSH_CODE;
    assign is_write = op_t'(tag_q[TAGWIDTH-1]) == OP_WRITE;
    assign any_hit = |hit;
    assign hit_dirty = ctl[hit_way][idx].dirty;
    assign vic_dirty = ctl[victim][idx].valid && ctl[victim][idx].dirty;
    assign write_hit = state == LOOKUP && any_hit && is_write && !is_flush;
    assign acc_way = state == LOOKUP ? hit_way : way_q;
    assign rd_way = state == LOOKUP ? (any_hit ? hit_way : victim) : way_q;
    assign wb_addr = (ctl[way_q][idx].tag << TSH) | (64'(idx) << LOGWIDTH);
    assign arb_respack = arb_respcyc;
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            valid_v[w] = ctl[w][idx].valid;
            hit[w] = ctl[w][idx].valid && ctl[w][idx].tag == req_tag;
            if (hit[w]) hit_way = AW'(w);
        end
    end
    always_comb begin
        fill_blk = arb_resp;
        if (is_write) fill_blk[wsel*WORDSIZE +: WORDSIZE] = wd_q;
    end
    dcache_lru_set #(.WAYS(WAYS), .AW(AW)) u_lru (
        .age(lru[idx]),
        .valid(valid_v),
        .way(acc_way),
        .victim(victim),
        .age_next(age_next)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = core_reqcyc ? LOOKUP : IDLE;
            LOOKUP:  state_n = any_hit ? (is_flush ? (hit_dirty ? EVRD : IDLE) : (is_write ? IDLE : RDWAIT))
                                       : (is_flush ? IDLE : (vic_dirty ? EVRD : FILL));
            RDWAIT:  state_n = cnt == '0 ? IDLE : RDWAIT;
            EVRD:    state_n = cnt == '0 ? WB : EVRD;
            WB:      state_n = arb_respcyc ? (is_flush ? IDLE : FILL) : WB;
            FILL:    state_n = arb_respcyc ? IDLE : FILL;
            default: state_n = IDLE;
        endcase
        respond = (state == LOOKUP && (is_flush ? !(any_hit && hit_dirty) : write_hit))
               || (state == RDWAIT && cnt == '0) || (state == WB && arb_respcyc && is_flush)
               || (state == FILL && arb_respcyc);
        lru_upd = write_hit || (state == RDWAIT && cnt == '0) || (state == FILL && arb_respcyc);
        arb_reqcyc = (state == WB || state == FILL) && !sent_q;
        arb_req = state == WB ? wb_addr : state == FILL ? req_q & ~64'((1 << LOGWIDTH) - 1) : '0;
        arb_reqtag = state == WB ? TAGWIDTH'(MEMWR_TAG) : state == FILL ? tag_q : '0;
        arb_reqdata = state == WB ? rd_q : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q <= '0;
            tag_q <= '0;
            wd_q <= '0;
            way_q <= '0;
            cnt <= '0;
            sent_q <= 1'b0;
            rd_q <= '0;
            core_reqack <= 1'b0;
            core_respcyc <= 1'b0;
            core_resp <= '0;
            core_resptag <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    ctl[w][s] <= '0;
                    lru[s][w] <= AW'(w);
                end
        end else begin
            assert (state != LOOKUP || $onehot0(hit));
            core_reqack <= state == IDLE && core_reqcyc;
            core_respcyc <= respond;
            sent_q <= state != state_n ? 1'b0 : sent_q | (arb_reqcyc & arb_reqack);
            if (state == IDLE && core_reqcyc) begin
                req_q <= core_req;
                tag_q <= core_reqtag;
                wd_q <= core_reqdata;
            end
            if (state == LOOKUP) begin
                way_q <= rd_way;
                cnt <= CW'(RDLAT - 1);
            end else if (cnt != '0) cnt <= cnt - 1'b1;
            if (state == LOOKUP || state == RDWAIT || state == EVRD) rd_q <= data[rd_way][idx];
            if (respond) begin
                core_resptag <= tag_q;
                core_resp <= state == RDWAIT ? rd_q : state == FILL ? fill_blk : '0;
            end
            if (lru_upd) lru[idx] <= age_next;
            if (write_hit) ctl[hit_way][idx].dirty <= 1'b1;
            if (state == LOOKUP && any_hit && is_flush && !hit_dirty) ctl[hit_way][idx].valid <= 1'b0;
            if (state == WB && arb_respcyc && is_flush) ctl[way_q][idx] <= '0;
            if (state == FILL && arb_respcyc) ctl[way_q][idx] <= '{valid: 1'b1, dirty: is_write, tag: req_tag};
        end
    end
    always_ff @(posedge clk) begin
        if (write_hit) data[hit_way][idx][wsel*WORDSIZE +: WORDSIZE] <= wd_q;
        if (state == FILL && arb_respcyc) data[way_q][idx] <= fill_blk;
    end
endmodule
